// File: rtl/vga_box_glider.sv
// ============================================================================
// Module   : vga_box_glider
// Purpose  : Keyboard-driven rectangle renderer. Moves a box by tap or glide,
//            cycles its colour and emits registered RGB pixels.
// Option   : VGA_BOX_GLIDER_WRAP_EN wraps the box around at the screen edges.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_box_glider #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int H_START     = 320,
    parameter int V_START     = 38,
    parameter int BOX_W       = 128,
    parameter int BOX_H       = 96,
    parameter int STEP_X      = 64,
    parameter int STEP_Y      = 48,
    parameter int TICK_CYCLES = 650000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] h_counter,
    input  logic [11:0] v_counter,
    input  logic        video_active,
    input  logic [7:0]  kbd_signal,
    input  logic        kbd_ready,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b,
    output logic [11:0] box_x,
    output logic [11:0] box_y,
    output logic        gliding
);

`ifdef VGA_BOX_GLIDER_WRAP_EN
    localparam bit c_wrap_en = 1'b1;
`else
    localparam bit c_wrap_en = 1'b0;
`endif

    localparam int               c_tick_w    = $clog2(TICK_CYCLES);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [11:0]      c_xmax      = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0]      c_ymax      = 12'(V_ACTIVE - BOX_H);
    localparam logic [11:0]      c_step_x    = 12'(STEP_X);
    localparam logic [11:0]      c_step_y    = 12'(STEP_Y);
    localparam logic [12:0]      c_h_start   = 13'(H_START);
    localparam logic [12:0]      c_v_start   = 13'(V_START);
    localparam logic [12:0]      c_box_w     = 13'(BOX_W);
    localparam logic [12:0]      c_box_h     = 13'(BOX_H);

    localparam logic [7:0] c_key_w     = 8'h57;
    localparam logic [7:0] c_key_s     = 8'h53;
    localparam logic [7:0] c_key_a     = 8'h41;
    localparam logic [7:0] c_key_d     = 8'h44;
    localparam logic [7:0] c_key_g     = 8'h47;
    localparam logic [7:0] c_key_space = 8'h20;
    localparam logic [7:0] c_key_c     = 8'h43;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GLIDE = 1'b1} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t                r_state, w_state_nxt;
    dir_t                  r_dir, w_dir_nxt, w_key_dir, w_step_dir;
    logic                  r_kbd_r1, r_kbd_r2;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [1:0]            r_color_idx, w_color_nxt;
    logic [11:0]           r_box_x, r_box_y, w_x_nxt, w_y_nxt;
    logic [12:0]           w_x_inc, w_y_inc, w_h_lo, w_h_hi, w_v_lo, w_v_hi;
    logic [23:0]           r_rgb, w_pal;
    logic                  w_evt, w_tick, w_step_en, w_hit;

    // Falling edge of the two-flop synchronised key strobe
    assign w_evt  = ~r_kbd_r1 & r_kbd_r2;
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_comb begin
        w_key_dir = DIR_RIGHT;
        case (kbd_signal)
            c_key_w: w_key_dir = DIR_UP;
            c_key_s: w_key_dir = DIR_DOWN;
            c_key_a: w_key_dir = DIR_LEFT;
            default: w_key_dir = DIR_RIGHT;
        endcase
    end

    // A key event always wins; a glide tick landing on the same cycle is lost
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_color_nxt = r_color_idx;
        w_step_en   = 1'b0;
        w_step_dir  = r_dir;
        if (w_evt) begin
            case (kbd_signal)
                c_key_w, c_key_a, c_key_s, c_key_d: begin
                    w_dir_nxt = w_key_dir;
                    if (r_state == ST_IDLE) begin
                        w_step_en  = 1'b1;
                        w_step_dir = w_key_dir;
                    end
                end
                c_key_g:     w_state_nxt = (r_state == ST_IDLE) ? ST_GLIDE : ST_IDLE;
                c_key_space: w_state_nxt = ST_IDLE;
                c_key_c:     w_color_nxt = r_color_idx + 2'd1;
                default:     ;
            endcase
        end else if (w_tick && (r_state == ST_GLIDE)) begin
            w_step_en = 1'b1;
        end
    end

    always_comb begin
        w_x_nxt = r_box_x;
        w_y_nxt = r_box_y;
        w_x_inc = {1'b0, r_box_x} + {1'b0, c_step_x};
        w_y_inc = {1'b0, r_box_y} + {1'b0, c_step_y};
        if (w_step_en) begin
            case (w_step_dir)
                DIR_LEFT:
                    if (c_wrap_en && r_box_x == 12'd0) w_x_nxt = c_xmax;
                    else if (r_box_x < c_step_x)       w_x_nxt = 12'd0;
                    else                               w_x_nxt = r_box_x - c_step_x;
                DIR_RIGHT:
                    if (c_wrap_en && r_box_x == c_xmax)  w_x_nxt = 12'd0;
                    else if (w_x_inc > {1'b0, c_xmax})   w_x_nxt = c_xmax;
                    else                                 w_x_nxt = w_x_inc[11:0];
                DIR_UP:
                    if (c_wrap_en && r_box_y == 12'd0) w_y_nxt = c_ymax;
                    else if (r_box_y < c_step_y)       w_y_nxt = 12'd0;
                    else                               w_y_nxt = r_box_y - c_step_y;
                default:
                    if (c_wrap_en && r_box_y == c_ymax)  w_y_nxt = 12'd0;
                    else if (w_y_inc > {1'b0, c_ymax})   w_y_nxt = c_ymax;
                    else                                 w_y_nxt = w_y_inc[11:0];
            endcase
        end
    end

    always_comb begin
        w_h_lo = c_h_start + {1'b0, r_box_x};
        w_h_hi = w_h_lo + c_box_w;
        w_v_lo = c_v_start + {1'b0, r_box_y};
        w_v_hi = w_v_lo + c_box_h;
        w_hit  = video_active
               && ({1'b0, h_counter} >= w_h_lo) && ({1'b0, h_counter} < w_h_hi)
               && ({1'b0, v_counter} >= w_v_lo) && ({1'b0, v_counter} < w_v_hi);
        case (r_color_idx)
            2'd0:    w_pal = 24'hA020F0;
            2'd1:    w_pal = 24'hFF0000;
            2'd2:    w_pal = 24'h00FF00;
            default: w_pal = 24'h00FFFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kbd_r1    <= 1'b0;
            r_kbd_r2    <= 1'b0;
            r_tick_cnt  <= '0;
            r_dir       <= DIR_RIGHT;
            r_color_idx <= 2'd0;
            r_box_x     <= 12'd0;
            r_box_y     <= 12'd0;
            r_rgb       <= 24'h0;
        end else begin
            r_kbd_r1    <= kbd_ready;
            r_kbd_r2    <= r_kbd_r1;
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_dir       <= w_dir_nxt;
            r_color_idx <= w_color_nxt;
            r_box_x     <= w_x_nxt;
            r_box_y     <= w_y_nxt;
            r_rgb       <= w_hit ? w_pal : 24'h0;
        end
    end

    assign rgb_r   = r_rgb[23:16];
    assign rgb_g   = r_rgb[15:8];
    assign rgb_b   = r_rgb[7:0];
    assign box_x   = r_box_x;
    assign box_y   = r_box_y;
    assign gliding = (r_state == ST_GLIDE);

endmodule

`default_nettype wire

// File: tb/tb_vga_box_glider.sv
// ============================================================================
// Module   : tb_vga_box_glider
// Purpose  : Randomised self-checking bench for vga_box_glider with an
//            arithmetic reference model (honours VGA_BOX_GLIDER_WRAP_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_box_glider;
    localparam int TICK    = 16;
    localparam int XMAX    = 1024 - 128;
    localparam int YMAX    = 768 - 96;
    localparam int H_START = 320;
    localparam int V_START = 38;

    logic        clk = 1'b0;
    logic        rst_n, video_active, kbd_ready, gliding;
    logic [11:0] h_counter, v_counter, box_x, box_y;
    logic [7:0]  kbd_signal, rgb_r, rgb_g, rgb_b;

    always #5 clk = ~clk;

    vga_box_glider #(.TICK_CYCLES(TICK)) dut (
        .clk(clk), .rst_n(rst_n), .h_counter(h_counter), .v_counter(v_counter),
        .video_active(video_active), .kbd_signal(kbd_signal), .kbd_ready(kbd_ready),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .box_x(box_x), .box_y(box_y), .gliding(gliding)
    );

    int          total = 0, bad = 0;
    bit          check_en = 0, pix_rand = 0;
    int          m_x, m_y, m_idx, m_cnt;
    bit          m_glide, k1, k2;
    logic [7:0]  m_dir;
    logic [23:0] m_rgb;

    function automatic logic [23:0] pal(int i);
        case (i)
            0:       return 24'hA020F0;
            1:       return 24'hFF0000;
            2:       return 24'h00FF00;
            default: return 24'h00FFFF;
        endcase
    endfunction

    function automatic int mv(int p, int step, int maxv, bit dec);
        if (dec) begin
`ifdef VGA_BOX_GLIDER_WRAP_EN
            if (p == 0) return maxv;
`endif
            return (p < step) ? 0 : p - step;
        end
`ifdef VGA_BOX_GLIDER_WRAP_EN
        if (p == maxv) return 0;
`endif
        return (p + step > maxv) ? maxv : p + step;
    endfunction

    function automatic void step(logic [7:0] d);
        case (d)
            "W": m_y = mv(m_y, 48, YMAX, 1'b1);
            "S": m_y = mv(m_y, 48, YMAX, 1'b0);
            "A": m_x = mv(m_x, 64, XMAX, 1'b1);
            default: m_x = mv(m_x, 64, XMAX, 1'b0);
        endcase
    endfunction

    // Reference model: evaluated on the same edge the DUT samples its inputs
    always @(posedge clk) begin
        bit evt, tick, hit;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_idx = 0; m_cnt = 0; m_glide = 0;
            m_dir = "D"; k1 = 0; k2 = 0; m_rgb = 24'h0;
        end else begin
            evt  = k2 && !k1;
            tick = (m_cnt == TICK - 1);
            hit  = video_active
                && h_counter >= H_START + m_x && h_counter < H_START + m_x + 128
                && v_counter >= V_START + m_y && v_counter < V_START + m_y + 96;
            m_rgb = hit ? pal(m_idx) : 24'h0;
            if (evt) begin
                case (kbd_signal)
                    "W", "A", "S", "D": begin
                        if (!m_glide) step(kbd_signal);
                        m_dir = kbd_signal;
                    end
                    "G": m_glide = !m_glide;
                    " ": m_glide = 0;
                    "C": m_idx = (m_idx + 1) % 4;
                    default: ;
                endcase
            end else if (tick && m_glide) begin
                step(m_dir);
            end
            m_cnt = (m_cnt + 1) % TICK;
            k2 = k1;
            k1 = kbd_ready;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic lit(string name, logic [31:0] dut_v, logic [31:0] mod_v, logic [31:0] exp_v);
        check({name, "_dut"}, dut_v, exp_v);
        check({name, "_model"}, mod_v, exp_v);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("rgb", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb});
            check("box_x", {20'h0, box_x}, m_x);
            check("box_y", {20'h0, box_y}, m_y);
            check("gliding", {31'h0, gliding}, {31'h0, m_glide});
        end
    end

    always @(negedge clk) begin
        if (pix_rand) begin
            video_active = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                h_counter = 12'($urandom_range(0, 1343));
                v_counter = 12'($urandom_range(0, 805));
            end else begin
                h_counter = 12'(H_START + m_x + $urandom_range(0, 135) - 4);
                v_counter = 12'(V_START + m_y + $urandom_range(0, 103) - 4);
            end
        end
    end

    // rst_at selects a post-release cycle to pulse reset in, discarding the pending event
    task automatic key(input logic [7:0] c, input int rst_at);
        @(negedge clk);
        kbd_signal = c;
        kbd_ready  = 1'b1;
        repeat (2) @(negedge clk);
        kbd_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rst_n = (j != rst_at);
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic set_pix(int h, int v, bit va);
        h_counter    = 12'(h);
        v_counter    = 12'(v);
        video_active = va;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] codes [8];
        codes = '{"W", "A", "S", "D", "G", " ", "C", 8'h00};
        rst_n = 1'b0; kbd_ready = 1'b0; kbd_signal = 8'h00;
        h_counter = 12'd0; v_counter = 12'd0; video_active = 1'b0;
        repeat (3) @(negedge clk);
        check_en = 1;
        lit("reset_x", {20'h0, box_x}, m_x, 0);
        lit("reset_rgb", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 0);
        lit("reset_glide", {31'h0, gliding}, {31'h0, m_glide}, 0);
        rst_n = 1'b1;

        key("D", -1); lit("d1_x", {20'h0, box_x}, m_x, 64);
        key("D", -1); lit("d2_x", {20'h0, box_x}, m_x, 128);
        key("D", -1); lit("d3_x", {20'h0, box_x}, m_x, 192);
        lit("d3_y", {20'h0, box_y}, m_y, 0);

        set_pix(H_START + 192, V_START, 1'b1);
        lit("pix_purple", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 32'hA020F0);
        repeat (5) key("C", -1);
        set_pix(H_START + 192, V_START, 1'b1);
        lit("pix_red", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 32'hFF0000);
        set_pix(H_START + 192 + 127, V_START + 95, 1'b1);
        lit("pix_corner", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 32'hFF0000);
        set_pix(H_START + 192 + 128, V_START, 1'b1);
        lit("pix_right_edge", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 0);
        set_pix(H_START + 192, V_START, 1'b0);
        lit("pix_blank", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 0);

        repeat (3) key("A", -1);
        lit("a3_x", {20'h0, box_x}, m_x, 0);
        key("A", -1);
`ifdef VGA_BOX_GLIDER_WRAP_EN
        lit("a_edge_x", {20'h0, box_x}, m_x, 896);
`else
        lit("a_edge_x", {20'h0, box_x}, m_x, 0);
`endif
        repeat (14) key("S", -1);
        lit("s14_y", {20'h0, box_y}, m_y, 672);
        key("S", -1);
`ifdef VGA_BOX_GLIDER_WRAP_EN
        lit("s_edge_y", {20'h0, box_y}, m_y, 0);
`else
        lit("s_edge_y", {20'h0, box_y}, m_y, 672);
`endif

        pix_rand = 1;
        key("G", -1);
        lit("glide_on", {31'h0, gliding}, {31'h0, m_glide}, 1);
        key("W", -1);
        repeat (16 * 16) @(negedge clk);
        key("S", -1);
        repeat (16 * 16) @(negedge clk);
`ifndef VGA_BOX_GLIDER_WRAP_EN
        lit("glide_y_hold", {20'h0, box_y}, m_y, 672);
`endif
        key(" ", -1);
        lit("glide_off", {31'h0, gliding}, {31'h0, m_glide}, 0);
        repeat (40) @(negedge clk);

        key("G", -1);
        key("D", -1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        lit("rst_glide", {31'h0, gliding}, {31'h0, m_glide}, 0);
        lit("rst_x", {20'h0, box_x}, m_x, 0);
        lit("rst_rgb", {8'h0, rgb_r, rgb_g, rgb_b}, {8'h0, m_rgb}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            logic [7:0] c;
            c = codes[$urandom_range(0, 7)];
            if (c == 8'h00) c = 8'($urandom_range(0, 255));
            key(c, ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 3)) : -1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        @(negedge clk);
        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
